// File: rtl/write_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : write_arbiter_if
//  Description : AW/W/B handshake bundle between two AXI write masters, two
//                slaves and the write arbiter, plus the arbiter's route codes.
//                Optional macro: WARB_WLAST_CHECK_EN (adds wlast_err).
//  Revision    : 1.0 - initial release
// ============================================================================
interface write_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4
);
  // Master-side request and data/response handshakes
  logic [ADDR_BITS-1:0] AWADDR_M0;
  logic [LEN_BITS-1:0]  AWLEN_M0;
  logic                 AWVALID_M0;
  logic [ADDR_BITS-1:0] AWADDR_M1;
  logic [LEN_BITS-1:0]  AWLEN_M1;
  logic                 AWVALID_M1;
  logic                 WVALID_M0;
  logic                 WLAST_M0;
  logic                 WVALID_M1;
  logic                 WLAST_M1;
  logic                 BREADY_M0;
  logic                 BREADY_M1;
  // Slave-side handshakes
  logic                 AWREADY_S0;
  logic                 AWREADY_S1;
  logic                 WREADY_S0;
  logic                 WREADY_S1;
  logic                 BVALID_S0;
  logic                 BVALID_S1;
  // Route codes driven by the arbiter
  logic [2:0]           AW_state;
  logic [2:0]           W_state;
  logic [2:0]           B_state;
  logic                 busy;
`ifdef WARB_WLAST_CHECK_EN
  logic                 wlast_err;
`endif

  // Arbiter's view of the bundle
  modport slave (
    input  AWADDR_M0, AWLEN_M0, AWVALID_M0,
    input  AWADDR_M1, AWLEN_M1, AWVALID_M1,
    input  WVALID_M0, WLAST_M0, WVALID_M1, WLAST_M1,
    input  BREADY_M0, BREADY_M1,
    input  AWREADY_S0, AWREADY_S1, WREADY_S0, WREADY_S1,
    input  BVALID_S0, BVALID_S1,
`ifdef WARB_WLAST_CHECK_EN
    output wlast_err,
`endif
    output AW_state, W_state, B_state, busy
  );

  // Environment's view of the bundle (drives requests, observes routes)
  modport master (
    output AWADDR_M0, AWLEN_M0, AWVALID_M0,
    output AWADDR_M1, AWLEN_M1, AWVALID_M1,
    output WVALID_M0, WLAST_M0, WVALID_M1, WLAST_M1,
    output BREADY_M0, BREADY_M1,
    output AWREADY_S0, AWREADY_S1, WREADY_S0, WREADY_S1,
    output BVALID_S0, BVALID_S1,
`ifdef WARB_WLAST_CHECK_EN
    input  wlast_err,
`endif
    input  AW_state, W_state, B_state, busy
  );
endinterface : write_arbiter_if
`default_nettype wire

// File: rtl/write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : write_arbiter
//  Description : Two-master / two-slave AXI write arbiter. Grants one AW
//                request at a time (M1 over M0), holds the route through the
//                W burst and the B response, and publishes per-channel route
//                codes (0 none, 1 M0->S0, 2 M1->S0, 3 M1->S1, 4 M0->S1).
//                Optional macro: WARB_WLAST_CHECK_EN adds a one-cycle
//                wlast_err pulse when WLAST disagrees with the AWLEN count.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_arbiter #(
  parameter int          ADDR_BITS = 32,
  parameter int          LEN_BITS  = 4,
  parameter logic [15:0] S0_TAG    = 16'h0000,
  parameter logic [15:0] S1_TAG    = 16'h0001
) (
  input  wire            ACLK,
  input  wire            ARESET,
  write_arbiter_if.slave bus
);

  // Phase lives in state[3:2]; route id (code-1) lives in state[1:0].
  localparam logic [1:0] c_PH_IDLE = 2'd0;
  localparam logic [1:0] c_PH_AW   = 2'd1;
  localparam logic [1:0] c_PH_W    = 2'd2;
  localparam logic [1:0] c_PH_B    = 2'd3;

  // Route ids: 0 M0->S0, 1 M1->S0, 2 M1->S1, 3 M0->S1
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_AW_M0S0 = 4'b0100, ST_AW_M1S0 = 4'b0101,
    ST_AW_M1S1 = 4'b0110, ST_AW_M0S1 = 4'b0111,
    ST_W_M0S0  = 4'b1000, ST_W_M1S0  = 4'b1001,
    ST_W_M1S1  = 4'b1010, ST_W_M0S1  = 4'b1011,
    ST_B_M0S0  = 4'b1100, ST_B_M1S0  = 4'b1101,
    ST_B_M1S1  = 4'b1110, ST_B_M0S1  = 4'b1111
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_aw_state;
  logic [2:0]  r_w_state;
  logic [2:0]  r_b_state;
  logic        r_busy;

  logic [1:0]  w_phase;
  logic [1:0]  w_rid;
  logic        w_mi;
  logic        w_sj;

  // Route code seen on a channel when the FSM sits in the given state
  function automatic logic [2:0] f_code(input logic [3:0] s, input logic [1:0] ph);
    if ((s[3:2] == ph) && (ph != c_PH_IDLE))
      return {1'b0, s[1:0]} + 3'd1;
    return 3'd0;
  endfunction

  assign w_phase = r_state[3:2];
  assign w_rid   = r_state[1:0];
  assign w_mi    = w_rid[0] ^ w_rid[1];   // ids 1 and 2 belong to M1
  assign w_sj    = w_rid[1];              // ids 2 and 3 target S1

  // Address decode of both masters' upper tags
  logic [15:0] w_tag_m0;
  logic [15:0] w_tag_m1;
  logic        w_m0_s0, w_m0_s1, w_m1_s0, w_m1_s1;
  logic        w_m0_req, w_m1_req;
  logic [1:0]  w_grant_rid;

  assign w_tag_m0 = bus.AWADDR_M0[31:16];
  assign w_tag_m1 = bus.AWADDR_M1[31:16];
  assign w_m0_s0  = (w_tag_m0 == S0_TAG);
  assign w_m0_s1  = (w_tag_m0 == S1_TAG);
  assign w_m1_s0  = (w_tag_m1 == S0_TAG);
  assign w_m1_s1  = (w_tag_m1 == S1_TAG);
  // An undecodable request is treated as no request so the other master can win
  assign w_m0_req = bus.AWVALID_M0 && (w_m0_s0 || w_m0_s1);
  assign w_m1_req = bus.AWVALID_M1 && (w_m1_s0 || w_m1_s1);

  // Fixed priority: M1 first, then M0; S0 tag wins if both tags were equal
  always_comb begin
    w_grant_rid = 2'd0;
    if (w_m1_req)
      w_grant_rid = w_m1_s0 ? 2'd1 : 2'd2;
    else if (w_m0_req)
      w_grant_rid = w_m0_s0 ? 2'd0 : 2'd3;
  end

  // Handshakes of the currently routed master/slave pair only
  logic w_awv, w_awr, w_wv, w_wl, w_wr, w_bv, w_br;
  logic w_aw_hs, w_w_hs, w_b_hs;

  assign w_awv   = w_mi ? bus.AWVALID_M1 : bus.AWVALID_M0;
  assign w_awr   = w_sj ? bus.AWREADY_S1 : bus.AWREADY_S0;
  assign w_wv    = w_mi ? bus.WVALID_M1  : bus.WVALID_M0;
  assign w_wl    = w_mi ? bus.WLAST_M1   : bus.WLAST_M0;
  assign w_wr    = w_sj ? bus.WREADY_S1  : bus.WREADY_S0;
  assign w_bv    = w_sj ? bus.BVALID_S1  : bus.BVALID_S0;
  assign w_br    = w_mi ? bus.BREADY_M1  : bus.BREADY_M0;
  assign w_aw_hs = (w_phase == c_PH_AW) && w_awv && w_awr;
  assign w_w_hs  = (w_phase == c_PH_W)  && w_wv  && w_wr;
  assign w_b_hs  = (w_phase == c_PH_B)  && w_bv  && w_br;

  // Next-state: IDLE -> AW -> W (until WLAST beat) -> B -> IDLE
  always_comb begin
    w_next = r_state;
    case (w_phase)
      c_PH_IDLE: if (w_m0_req || w_m1_req) w_next = state_t'({c_PH_AW, w_grant_rid});
      c_PH_AW:   if (w_aw_hs)              w_next = state_t'({c_PH_W, w_rid});
      c_PH_W:    if (w_w_hs && w_wl)       w_next = state_t'({c_PH_B, w_rid});
      default:   if (w_b_hs)               w_next = ST_IDLE;
    endcase
  end

  // State register with route codes registered from the next state
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_aw_state <= 3'd0;
      r_w_state  <= 3'd0;
      r_b_state  <= 3'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_aw_state <= f_code(w_next, c_PH_AW);
      r_w_state  <= f_code(w_next, c_PH_W);
      r_b_state  <= f_code(w_next, c_PH_B);
      r_busy     <= (w_next[3:2] != c_PH_IDLE);
    end
  end

  assign bus.AW_state = r_aw_state;
  assign bus.W_state  = r_w_state;
  assign bus.B_state  = r_b_state;
  assign bus.busy     = r_busy;

`ifdef WARB_WLAST_CHECK_EN
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS:0]   r_beat;
  logic                r_wlast_err;
  logic [LEN_BITS-1:0] w_awlen;
  logic                w_beat_is_last;

  assign w_awlen        = w_mi ? bus.AWLEN_M1 : bus.AWLEN_M0;
  assign w_beat_is_last = (r_beat == {1'b0, r_len});

  // Beat counting against AWLEN; counter saturates instead of wrapping
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_len       <= '0;
      r_beat      <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wlast_err <= 1'b0;
      if (w_aw_hs) begin
        r_len  <= w_awlen;
        r_beat <= '0;
      end else if (w_w_hs) begin
        r_wlast_err <= (w_wl != w_beat_is_last);
        if (r_beat != '1)
          r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign bus.wlast_err = r_wlast_err;

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.AWADDR_M0[15:0], bus.AWADDR_M1[15:0]};
`else
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.AWADDR_M0[15:0], bus.AWADDR_M1[15:0],
                           bus.AWLEN_M0, bus.AWLEN_M1};
`endif

endmodule : write_arbiter
`default_nettype wire

// File: tb/tb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_write_arbiter
//  Description : Self-checking bench for write_arbiter: directed scenarios
//                with literal expectations, then randomized traffic compared
//                every cycle against a transaction-level model.
//                Optional macro: WARB_WLAST_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  write_arbiter_if #(.ADDR_BITS(32), .LEN_BITS(4)) u_if ();

  write_arbiter #(
    .ADDR_BITS(32), .LEN_BITS(4), .S0_TAG(16'h0000), .S1_TAG(16'h0001)
  ) u_dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (u_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- transaction-level reference model ----------------
  // One in-flight transaction: phase 0 idle, 1 address, 2 data, 3 response.
  int code [2][2] = '{'{1, 4}, '{2, 3}};   // code[master][slave]
  int m_ph = 0, m_mi = 0, m_sj = 0, m_len = 0, m_cnt = 0;
  bit m_err = 1'b0;

  function automatic int decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return -1;
  endfunction

  always @(posedge ACLK) begin : p_model
    logic [31:0] a [2];
    bit v[2], awr[2], wv[2], wl[2], wr[2], bv[2], br[2];
    int ln[2];
    a[0] = u_if.AWADDR_M0;  a[1] = u_if.AWADDR_M1;
    v[0] = u_if.AWVALID_M0; v[1] = u_if.AWVALID_M1;
    ln[0] = int'(u_if.AWLEN_M0); ln[1] = int'(u_if.AWLEN_M1);
    wv[0] = u_if.WVALID_M0; wv[1] = u_if.WVALID_M1;
    wl[0] = u_if.WLAST_M0;  wl[1] = u_if.WLAST_M1;
    br[0] = u_if.BREADY_M0; br[1] = u_if.BREADY_M1;
    awr[0] = u_if.AWREADY_S0; awr[1] = u_if.AWREADY_S1;
    wr[0]  = u_if.WREADY_S0;  wr[1]  = u_if.WREADY_S1;
    bv[0]  = u_if.BVALID_S0;  bv[1]  = u_if.BVALID_S1;
    m_err = 1'b0;
    if (ARESET) begin
      m_ph = 0; m_len = 0; m_cnt = 0;
    end else begin
      case (m_ph)
        0: begin
          // candidates in priority order: M1 then M0
          for (int k = 1; k >= 0; k--) begin
            if (m_ph == 0 && v[k] && decode(a[k]) >= 0) begin
              m_mi = k; m_sj = decode(a[k]); m_ph = 1;
            end
          end
        end
        1: if (v[m_mi] && awr[m_sj]) begin
             m_len = ln[m_mi]; m_cnt = 0; m_ph = 2;
           end
        2: if (wv[m_mi] && wr[m_sj]) begin
             m_err = (wl[m_mi] != (m_cnt == m_len));
             m_cnt++;
             if (wl[m_mi]) m_ph = 3;
           end
        default: if (bv[m_sj] && br[m_mi]) m_ph = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge ACLK) begin
    if (chk_en) begin
      check("AW_state", u_if.AW_state, (m_ph == 1) ? code[m_mi][m_sj] : 0);
      check("W_state",  u_if.W_state,  (m_ph == 2) ? code[m_mi][m_sj] : 0);
      check("B_state",  u_if.B_state,  (m_ph == 3) ? code[m_mi][m_sj] : 0);
      check("busy",     u_if.busy,     (m_ph != 0) ? 1 : 0);
`ifdef WARB_WLAST_CHECK_EN
      check("wlast_err", u_if.wlast_err, m_err ? 1 : 0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ACLK); #2;
  endtask

  task automatic clear_inputs();
    u_if.AWADDR_M0 = '0; u_if.AWLEN_M0 = '0; u_if.AWVALID_M0 = 1'b0;
    u_if.AWADDR_M1 = '0; u_if.AWLEN_M1 = '0; u_if.AWVALID_M1 = 1'b0;
    u_if.WVALID_M0 = 1'b0; u_if.WLAST_M0 = 1'b0;
    u_if.WVALID_M1 = 1'b0; u_if.WLAST_M1 = 1'b0;
    u_if.BREADY_M0 = 1'b0; u_if.BREADY_M1 = 1'b0;
    u_if.AWREADY_S0 = 1'b0; u_if.AWREADY_S1 = 1'b0;
    u_if.WREADY_S0 = 1'b0; u_if.WREADY_S1 = 1'b0;
    u_if.BVALID_S0 = 1'b0; u_if.BVALID_S1 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESET = 1'b1;
    tick(); tick();
    ARESET = 1'b0;
  endtask

  task automatic lit_all(input string tag, input int aw, input int w, input int b, input int bz);
    check({tag, ".AW"},   u_if.AW_state, aw);
    check({tag, ".W"},    u_if.W_state,  w);
    check({tag, ".B"},    u_if.B_state,  b);
    check({tag, ".busy"}, u_if.busy,     bz);
  endtask

  initial begin
    ARESET = 1'b1;
    clear_inputs();
    tick();
    chk_en = 1'b1;
    tick();
    ARESET = 1'b0;
    lit_all("reset", 0, 0, 0, 0);

    // T1: M1->S1, AWLEN=3, four beats
    u_if.AWADDR_M1 = 32'h0001_0040; u_if.AWLEN_M1 = 4'd3; u_if.AWVALID_M1 = 1'b1;
    u_if.AWREADY_S1 = 1'b1;
    tick(); lit_all("t1.aw", 3, 0, 0, 1);
    tick(); lit_all("t1.w0", 0, 3, 0, 1);
    u_if.AWVALID_M1 = 1'b0;
    u_if.WVALID_M1 = 1'b1; u_if.WREADY_S1 = 1'b1;
    tick(); lit_all("t1.w1", 0, 3, 0, 1);
    tick(); lit_all("t1.w2", 0, 3, 0, 1);
    tick(); lit_all("t1.w3", 0, 3, 0, 1);
    u_if.WLAST_M1 = 1'b1;
    tick(); lit_all("t1.b", 0, 0, 3, 1);
    u_if.WVALID_M1 = 1'b0; u_if.WLAST_M1 = 1'b0;
    u_if.BVALID_S1 = 1'b1; u_if.BREADY_M1 = 1'b1;
    tick(); lit_all("t1.idle", 0, 0, 0, 0);
    clear_inputs();

    // T2: simultaneous requests to S0, M1 wins, M0 follows after one IDLE
    u_if.AWADDR_M0 = 32'h0000_0100; u_if.AWVALID_M0 = 1'b1;
    u_if.AWADDR_M1 = 32'h0000_0200; u_if.AWVALID_M1 = 1'b1;
    tick(); lit_all("t2.aw", 2, 0, 0, 1);
    u_if.AWREADY_S0 = 1'b1;
    tick(); lit_all("t2.w", 0, 2, 0, 1);
    u_if.AWVALID_M1 = 1'b0; u_if.AWREADY_S0 = 1'b0;
    u_if.WVALID_M1 = 1'b1; u_if.WLAST_M1 = 1'b1; u_if.WREADY_S0 = 1'b1;
    tick(); lit_all("t2.b", 0, 0, 2, 1);
    u_if.WVALID_M1 = 1'b0; u_if.WLAST_M1 = 1'b0; u_if.WREADY_S0 = 1'b0;
    u_if.BVALID_S0 = 1'b1; u_if.BREADY_M1 = 1'b1;
    tick(); lit_all("t2.gap", 0, 0, 0, 0);
    u_if.BVALID_S0 = 1'b0; u_if.BREADY_M1 = 1'b0;
    tick(); lit_all("t2.m0", 1, 0, 0, 1);
    do_reset();

    // T3: undecodable M1 falls through to M0; alone it is never granted
    u_if.AWADDR_M1 = 32'h0002_0000; u_if.AWVALID_M1 = 1'b1;
    u_if.AWADDR_M0 = 32'h0000_0000; u_if.AWVALID_M0 = 1'b1;
    tick(); lit_all("t3.fall", 1, 0, 0, 1);
    do_reset();
    u_if.AWADDR_M1 = 32'h0002_0000; u_if.AWVALID_M1 = 1'b1;
    tick(); lit_all("t3.none0", 0, 0, 0, 0);
    tick(); lit_all("t3.none1", 0, 0, 0, 0);
    clear_inputs();

    // T4: M0->S1 single beat with WREADY stalled three cycles
    u_if.AWADDR_M0 = 32'h0001_0000; u_if.AWLEN_M0 = 4'd0; u_if.AWVALID_M0 = 1'b1;
    u_if.AWREADY_S1 = 1'b1;
    tick(); lit_all("t4.aw", 4, 0, 0, 1);
    tick(); lit_all("t4.w0", 0, 4, 0, 1);
    clear_inputs();
    u_if.WVALID_M0 = 1'b1; u_if.WLAST_M0 = 1'b1;
    tick(); lit_all("t4.w1", 0, 4, 0, 1);
    tick(); lit_all("t4.w2", 0, 4, 0, 1);
    tick(); lit_all("t4.w3", 0, 4, 0, 1);
    u_if.WREADY_S1 = 1'b1;
    tick(); lit_all("t4.b", 0, 0, 4, 1);
    clear_inputs();
    u_if.BVALID_S1 = 1'b1; u_if.BREADY_M0 = 1'b1;
    tick(); lit_all("t4.idle", 0, 0, 0, 0);
    clear_inputs();

    // T5: reset during second beat of an M1->S0 AWLEN=7 burst
    u_if.AWADDR_M1 = 32'h0000_0000; u_if.AWLEN_M1 = 4'd7; u_if.AWVALID_M1 = 1'b1;
    u_if.AWREADY_S0 = 1'b1;
    tick(); tick(); lit_all("t5.w", 0, 2, 0, 1);
    u_if.AWVALID_M1 = 1'b0;
    u_if.WVALID_M1 = 1'b1; u_if.WREADY_S0 = 1'b1;
    tick(); lit_all("t5.beat1", 0, 2, 0, 1);
    ARESET = 1'b1;
    tick(); lit_all("t5.rst", 0, 0, 0, 0);
    ARESET = 1'b0;
    clear_inputs();
    u_if.AWADDR_M0 = 32'h0000_0000; u_if.AWVALID_M0 = 1'b1;
    tick(); lit_all("t5.fresh", 1, 0, 0, 1);
    do_reset();

`ifdef WARB_WLAST_CHECK_EN
    // T6: AWLEN=2 burst terminated early on beat 2
    u_if.AWADDR_M0 = 32'h0000_0000; u_if.AWLEN_M0 = 4'd2; u_if.AWVALID_M0 = 1'b1;
    u_if.AWREADY_S0 = 1'b1;
    tick(); tick();
    clear_inputs();
    u_if.WVALID_M0 = 1'b1; u_if.WREADY_S0 = 1'b1;
    tick(); check("t6.err0", u_if.wlast_err, 0);
    u_if.WLAST_M0 = 1'b1;
    tick(); check("t6.err1", u_if.wlast_err, 1); check("t6.B", u_if.B_state, 1);
    clear_inputs();
    tick(); check("t6.err2", u_if.wlast_err, 0);
    do_reset();
`endif

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] t0, t1;
      t0 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2));
      t1 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2));
      ARESET          = ($urandom_range(0, 299) == 0);
      u_if.AWADDR_M0  = {t0, 16'($urandom)};
      u_if.AWADDR_M1  = {t1, 16'($urandom)};
      u_if.AWLEN_M0   = 4'($urandom);
      u_if.AWLEN_M1   = 4'($urandom);
      u_if.AWVALID_M0 = ($urandom_range(0, 1) == 1);
      u_if.AWVALID_M1 = ($urandom_range(0, 2) == 0);
      u_if.WVALID_M0  = ($urandom_range(0, 3) != 0);
      u_if.WVALID_M1  = ($urandom_range(0, 3) != 0);
      u_if.WLAST_M0   = ($urandom_range(0, 3) == 0);
      u_if.WLAST_M1   = ($urandom_range(0, 3) == 0);
      u_if.BREADY_M0  = ($urandom_range(0, 2) != 0);
      u_if.BREADY_M1  = ($urandom_range(0, 2) != 0);
      u_if.AWREADY_S0 = ($urandom_range(0, 2) != 0);
      u_if.AWREADY_S1 = ($urandom_range(0, 2) != 0);
      u_if.WREADY_S0  = ($urandom_range(0, 2) != 0);
      u_if.WREADY_S1  = ($urandom_range(0, 2) != 0);
      u_if.BVALID_S0  = ($urandom_range(0, 1) == 1);
      u_if.BVALID_S1  = ($urandom_range(0, 1) == 1);
      tick();
    end
    ARESET = 1'b0;
    clear_inputs();
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_write_arbiter
`default_nettype wire
